// File: rtl/islem_pkg.sv
// islem_pkg: op codes, controller states and step count shared by the arithmetic unit
package islem_pkg;
    typedef enum logic [1:0] {TOPLA = 2'b00, CIKAR = 2'b01, CARP = 2'b10, BOL = 2'b11} islem_e;
    typedef enum logic [1:0] {BOS = 2'b00, HESAP = 2'b01, YAZ = 2'b10} durum_e;
    localparam int ADIM_SAYISI = 16;
endpackage

// File: rtl/bolme_adimi.sv
// bolme_adimi: one combinational restoring divide step producing one quotient bit
module bolme_adimi #(
    parameter int W = 32
) (
    input  logic [W-1:0] kalan_in,
    input  logic         bit_in,
    input  logic [W-1:0] bolen,
    output logic [W-1:0] kalan_out,
    output logic         q
);
    logic [W:0]   kaydirilmis;
    logic [W-1:0] fark;
    assign kaydirilmis = {kalan_in, bit_in};
    // When the divisor fits, the true difference is below 2^W, so the low bits are exact
    assign fark        = kaydirilmis[W-1:0] - bolen;
    assign q           = kaydirilmis >= {1'b0, bolen};
    assign kalan_out   = q ? fark : kaydirilmis[W-1:0];
endmodule

// File: rtl/islem_birimi.sv
// islem_birimi: multi-cycle unsigned add/sub/mul/div unit that writes each result to memory
module islem_birimi
    import islem_pkg::*;
#(
    parameter int ADRES_W = 13,
    parameter int VERI_W  = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               basla,
    input  logic [1:0]         islem_turu,
    input  logic [VERI_W-1:0]  sayi1,
    input  logic [VERI_W-1:0]  sayi2,
    input  logic [ADRES_W-1:0] adres,
    output logic               mesgul,
    output logic               yaz_en,
    output logic [ADRES_W-1:0] yaz_adres,
    output logic [VERI_W-1:0]  yaz_veri,
    output logic               tasma
);
    durum_e              durum, durum_n;
    islem_e              islem;
    logic [4:0]          sayac;
    logic [VERI_W-1:0]   a, b;
    logic [2*VERI_W-1:0] carpilan, birikim, birikim_n;
    logic [VERI_W:0]     toplam, fark;
    logic [VERI_W-1:0]   kalan1, kalan2, sonuc;
    logic                q1, q2, son_adim, sonuc_tasma;

    // a holds the dividend and collects quotient bits; birikim low half is the partial remainder
    bolme_adimi #(.W(VERI_W)) u_adim1 (
        .kalan_in (birikim[VERI_W-1:0]),
        .bit_in   (a[VERI_W-1]),
        .bolen    (b),
        .kalan_out(kalan1),
        .q        (q1)
    );

    bolme_adimi #(.W(VERI_W)) u_adim2 (
        .kalan_in (kalan1),
        .bit_in   (a[VERI_W-2]),
        .bolen    (b),
        .kalan_out(kalan2),
        .q        (q2)
    );

    assign toplam      = {1'b0, a} + {1'b0, b};
    assign fark        = {1'b0, a} - {1'b0, b};
    assign birikim_n   = birikim + (b[0] ? carpilan : '0) + (b[1] ? carpilan << 1 : '0);
    assign son_adim    = (islem == TOPLA) || (islem == CIKAR) || (sayac == 5'(ADIM_SAYISI - 1));
    assign sonuc       = islem == TOPLA ? toplam[VERI_W-1:0] :
                         islem == CIKAR ? fark[VERI_W-1:0] :
                         islem == CARP  ? birikim_n[VERI_W-1:0] : {a[VERI_W-3:0], q1, q2};
    assign sonuc_tasma = islem == TOPLA ? toplam[VERI_W] :
                         islem == CIKAR ? fark[VERI_W] :
                         islem == CARP  ? |birikim_n[2*VERI_W-1:VERI_W] : (b == '0);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) durum <= BOS;
        else      durum <= durum_n;
    end

    // Next state: idle until start, compute until the last step, then one write cycle
    always_comb begin
        durum_n = durum;
        case (durum)
            BOS:     durum_n = basla ? HESAP : BOS;
            HESAP:   durum_n = son_adim ? YAZ : HESAP;
            default: durum_n = BOS;
        endcase
    end

    // Operand capture, two-bit-per-cycle datapath and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            islem     <= TOPLA;
            sayac     <= '0;
            a         <= '0;
            b         <= '0;
            carpilan  <= '0;
            birikim   <= '0;
            mesgul    <= 1'b0;
            yaz_en    <= 1'b0;
            yaz_adres <= '0;
            yaz_veri  <= '0;
            tasma     <= 1'b0;
        end else begin
            mesgul <= durum_n != BOS;
            yaz_en <= durum_n == YAZ;
            if (durum == BOS && basla) begin
                islem     <= islem_e'(islem_turu);
                a         <= sayi1;
                b         <= sayi2;
                carpilan  <= {{VERI_W{1'b0}}, sayi1};
                birikim   <= '0;
                sayac     <= '0;
                yaz_adres <= adres;
            end else if (durum == HESAP) begin
                sayac    <= son_adim ? 5'd0 : sayac + 5'd1;
                a        <= {a[VERI_W-3:0], q1, q2};
                b        <= islem == BOL ? b : b >> 2;
                carpilan <= carpilan << 2;
                birikim  <= islem == BOL ? {{VERI_W{1'b0}}, kalan2} : birikim_n;
                if (son_adim) begin
                    yaz_veri <= sonuc;
                    tasma    <= sonuc_tasma;
                end
            end
        end
    end
endmodule

// File: doc/islem_birimi.md
ISLEM_BIRIMI -- requirements
Module: islem_birimi

Interface
REQ-001 Parameter: ADRES_W, default 13, memory address width.
REQ-002 Parameter: VERI_W, default 32, operand/result width; only 32 is supported.
REQ-003 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-004 Port: rst  input  1  reset, asynchronous, active-low.
REQ-005 Port: basla  input  1  one-cycle start strobe; operands valid in the same cycle.
REQ-006 Port: islem_turu  input  2  operation: 00 add, 01 sub, 10 mul, 11 div.
REQ-007 Port: sayi1  input  32  first operand, unsigned.
REQ-008 Port: sayi2  input  32  second operand, unsigned.
REQ-009 Port: adres  input  13  result destination address.
REQ-010 Port: mesgul  output  1  busy flag; high from the accepting edge through the write cycle.
REQ-011 Port: yaz_en  output  1  one-cycle memory write strobe.
REQ-012 Port: yaz_adres  output  13  write address, valid while yaz_en is high.
REQ-013 Port: yaz_veri  output  32  write data, valid while yaz_en is high.
REQ-014 Port: tasma  output  1  overflow/error flag for the last result; held until the next write.

Function
REQ-015 State machine SHALL have states BOS, HESAP, YAZ; every output SHALL be registered.
REQ-016 In BOS, basla=1 SHALL capture the operands, op and address, set mesgul and move to HESAP.
REQ-017 A basla pulse arriving while mesgul=1 SHALL be ignored and SHALL NOT disturb the captured operands.
REQ-018 Add SHALL produce a 32-bit sum; tasma SHALL equal the carry out.
REQ-019 Sub SHALL produce sayi1-sayi2 modulo 2^32; tasma SHALL be 1 when sayi2>sayi1.
REQ-020 Add/sub SHALL spend 1 cycle in HESAP.
REQ-021 Mul SHALL be an iterative shift-add retiring 2 multiplier bits per cycle, taking 16 cycles in HESAP.
REQ-022 Mul result SHALL be the low 32 bits of the product; tasma SHALL be 1 if the high 32 bits are nonzero.
REQ-023 Div SHALL be restoring unsigned division producing 2 quotient bits per cycle, taking 16 cycles in HESAP, with result = quotient.
REQ-024 Div by zero SHALL give yaz_veri=32'hFFFFFFFF and tasma=1 after the same 16-cycle latency.
REQ-025 A 5-bit iteration counter SHALL count 0..15 in HESAP and leave HESAP on terminal count; the counter SHALL be unused for add/sub.
REQ-026 YAZ SHALL last exactly 1 cycle with yaz_en=1, then return to BOS with mesgul=0.
REQ-027 Latency, counted from the accepting edge to the first cycle in which yaz_en=1: add/sub 2 edges, mul/div 17 edges.
REQ-028 basla is accepted again on the first edge after yaz_en falls; back-to-back starts SHALL be accepted with no further gap.
REQ-029 yaz_adres SHALL equal the captured adres; yaz_veri and tasma SHALL hold their last value until the next YAZ.
REQ-030 Total worst-case occupancy (19 cycles) SHALL fit inside the 24-cycle instruction frame of the instruction splitter.

Reset
REQ-031 rst=0 SHALL asynchronously force: state BOS, mesgul=0, yaz_en=0, yaz_adres=0, yaz_veri=0, tasma=0, counter=0, and all internal registers=0.
REQ-032 Reset during HESAP or YAZ SHALL abort the operation with no write strobe.
REQ-033 After rst returns to 1, the first rising edge SHALL accept basla.

Structure
REQ-034 Package islem_pkg SHALL hold: the op codes (TOPLA=00, CIKAR=01, CARP=10, BOL=11), the state encoding, and the constant ADIM_SAYISI=16.
REQ-035 Sub-module bolme_adimi SHALL implement one combinational restoring divide step (partial remainder, divisor -> next remainder, quotient bit); the top module SHALL instantiate it twice per cycle.
REQ-036 The multiply datapath SHALL remain inline in islem_birimi.

Verification
REQ-037 Add 0x0000_0005+0x0000_0007, adres=0x0A0: yaz_en 2 edges after the accepting edge, yaz_veri=0x0000_000C, yaz_adres=0x0A0, tasma=0.
REQ-038 Add 0xFFFF_FFFF+1 -> yaz_veri=0, tasma=1; sub 3-5 -> yaz_veri=0xFFFF_FFFE, tasma=1.
REQ-039 Mul 0x0001_0000*0x0001_0000 -> 17-edge latency, yaz_veri=0, tasma=1; mul 1234*5678 -> yaz_veri=7006652, tasma=0.
REQ-040 Div 100/7 -> yaz_veri=14, tasma=0; div 9/0 -> yaz_veri=0xFFFF_FFFF, tasma=1, same latency.
REQ-041 basla pulsed mid-mul with other operands -> ignored, original result written; rst=0 at HESAP cycle 8 -> no yaz_en, all outputs 0 immediately.
